// File: rtl/mini_cpu_pkg.sv
// Shared encodings for the mini-cpu control path: ALU codes, opcodes, mux selects, FSM states.
package mini_cpu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps alu_op/funct3/funct7_5 to an ALU code; unsupported funct3 flags funct_illegal and yields add.
module alu_decoder
  import mini_cpu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_ctrl,
  output logic       funct_illegal
);

  always_comb begin
    alu_ctrl      = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      // beq is the only branch supported
      ALUOP_SUB: begin
        alu_ctrl      = ALU_SUB;
        funct_illegal = (funct3 != 3'b000);
      end
      default: begin
        case (funct3)
          3'b000:  alu_ctrl = (alu_op == ALUOP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: funct_illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore multicycle control FSM for the mini-cpu (RV64I subset), shared mem port with mem_ready stalls.
// Define MULTICYCLE_CTRL_TRAP_EN to trap unknown opcodes / funct3 in a terminal ILLEGAL state.
module multicycle_ctrl
  import mini_cpu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("multicycle_ctrl: XLEN must be 32 or 64");
  end

  state_e     state, state_nxt, cur;
  ctrl_t      c;
  logic [2:0] dec_ctrl;
  logic       funct_illegal;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // reset presents FETCH outputs immediately; strobes are masked below
  assign cur = rst ? S_FETCH : state;

  alu_decoder u_alu_dec (
    .alu_op        (c.alu_op),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .alu_ctrl      (dec_ctrl),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    c         = '0;
    c.alu_op  = ALUOP_ADD;
    state_nxt = cur;
    case (cur)
      S_FETCH: begin
        c.result_src = RES_ALU;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.ir_write   = mem_ready;
        c.pc_write   = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = imm_src_of(opcode);
        // decoder runs here only to vet funct3; alu_ctrl stays add
        case (opcode)
          OP_RTYPE:  c.alu_op = ALUOP_R;
          OP_ITYPE:  c.alu_op = ALUOP_I;
          OP_BRANCH: c.alu_op = ALUOP_SUB;
          default:   c.alu_op = ALUOP_ADD;
        endcase
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECUTER;
          OP_ITYPE:          state_nxt = S_EXECUTEI;
          OP_BRANCH:         state_nxt = S_BEQ;
          OP_JAL:            state_nxt = S_JAL;
`ifdef MULTICYCLE_CTRL_TRAP_EN
          default:           state_nxt = S_ILLEGAL;
`else
          default:           state_nxt = S_FETCH;
`endif
        endcase
`ifdef MULTICYCLE_CTRL_TRAP_EN
        if (funct_illegal) state_nxt = S_ILLEGAL;
`endif
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        state_nxt   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        c.result_src = RES_RDATA;
        c.reg_write  = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_R;
        state_nxt   = S_ALUWB;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_I;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.pc_write   = zero;
        state_nxt    = S_FETCH;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
        state_nxt    = S_ALUWB;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      S_ILLEGAL: begin
        c.illegal = 1'b1;
        state_nxt = S_ILLEGAL;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  assign pc_write   = c.pc_write  & ~rst;
  assign ir_write   = c.ir_write  & ~rst;
  assign mem_write  = c.mem_write & ~rst;
  assign reg_write  = c.reg_write & ~rst;
  assign adr_src    = c.adr_src;
  assign result_src = c.result_src;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign imm_src    = c.imm_src;
  // unsupported funct3 falls back to add
  assign alu_ctrl   = (cur == S_DECODE || funct_illegal) ? ALU_ADD : dec_ctrl;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  assign illegal    = c.illegal & ~rst;
`else
  assign illegal    = 1'b0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the mini-cpu datapath: a Moore FSM that sequences fetch, decode, execute, memory and writeback for an RV64I subset. It sits directly upstream of the ALU, driving its `alu_ctrl` code and operand-select muxes, and also drives the PC, instruction-register, memory and register-file strobes. Instruction and data memory share a port, and every memory access stalls on a `mem_ready` handshake.

## Interface
- `XLEN`, 64: datapath width. The FSM itself does not depend on it; it is passed for consistency.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7_5` in 1: `instr[30]`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: the memory access in progress completes this cycle.
- `pc_write` out 1: load PC from the result bus.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_write` out 1: store strobe.
- `ir_write` out 1: latch instruction and old PC.
- `result_src` out 2: result bus select. 00 = ALUOut, 01 = read data, 10 = ALU result.
- `alu_src_a` out 2: ALU A select. 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b` out 2: ALU B select. 00 = rs2, 01 = immediate, 10 = constant 4.
- `imm_src` out 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `reg_write` out 1: register-file write enable.
- `alu_ctrl` out 3: ALU operation. 000 and, 001 or, 010 add, 110 sub, 111 slt.
- `illegal` out 1: illegal-instruction flag (see Configuration).

## Operation
States, each followed by its outputs and next state. Outputs not listed are 0.
- FETCH: `adr_src=0`, `a=00`, `b=10`, add, `result_src=10`. `ir_write` and `pc_write` equal `mem_ready`. Goes to DECODE when `mem_ready`; otherwise stays in FETCH.
- DECODE: `a=01`, `b=01`, add (branch/jump target into ALUOut). `imm_src` is taken from `opcode`. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else → ILLEGAL
- MEMADR: `a=10`, `b=01`, add. Goes to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: `adr_src=1`. Goes to MEMWB when `mem_ready`; otherwise stays.
- MEMWB: `result_src=01`, `reg_write=1`. Goes to FETCH.
- MEMWRITE: `adr_src=1`, `mem_write=1`. `mem_write` is held high until `mem_ready`, then goes to FETCH.
- EXECUTER: `a=10`, `b=00`, `alu_ctrl` from the decoder. Goes to ALUWB.
- EXECUTEI: `a=10`, `b=01`, `alu_ctrl` from the decoder. Goes to ALUWB.
- ALUWB: `result_src=00`, `reg_write=1`. Goes to FETCH.
- BEQ: `a=10`, `b=00`, sub, `result_src=00`, `pc_write=zero`. Goes to FETCH.
- JAL: `a=01`, `b=10`, add, `result_src=00`, `pc_write=1`. Goes to ALUWB, which writes old PC + 4 to rd.

ALU decode:
- R-type by `funct3`:
  - 000: add, or sub when `funct7_5=1`
  - 010: slt
  - 110: or
  - 111: and
- I-type uses the same `funct3` map; `funct7_5` is ignored.
- beq requires `funct3=000`.
- Any other `funct3` on R-type, I-type or branch is illegal.
- In states that do not use the decoder, `alu_ctrl` is forced to add, or to sub in BEQ.

Load/store `funct3` (access width) is passed to memory untouched and is not checked here.

## Timing
- All outputs are combinational functions of the state register plus instruction fields. There are no Mealy terms except `mem_ready` gating in FETCH and `zero` in BEQ.
- Reset: `rst` sampled high puts the state in FETCH.
  - While `rst` is high, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal` are forced to 0.
  - Other outputs take their FETCH values.
  - Reset mid-access abandons the access with no strobe asserted.
- Cycle counts with `mem_ready` constantly 1:
  - load: 5
  - store: 4
  - R-type and I-type: 4
  - beq: 3
  - jal: 4
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `mem_ready` is ignored in all other states.
- Instruction fields are sampled only from DECODE onward. The IR is stable there because `ir_write` is 0 outside FETCH.

## Configuration
- `MULTICYCLE_CTRL_TRAP_EN` defined:
  - ILLEGAL is a terminal state; `illegal=1`, all strobes 0.
  - The FSM leaves ILLEGAL only on `rst`.
  - Illegal `funct3` found in DECODE also enters ILLEGAL.
- Undefined:
  - ILLEGAL is not implemented. Unknown opcodes go DECODE → FETCH, acting as a NOP.
  - Illegal `funct3` decodes as add.
  - `illegal` is tied to 0.

## Structure
- `mini_cpu_pkg` holds:
  - `alu_ctrl` codes
  - opcode constants
  - mux-select encodings for `result_src`, `alu_src_a`, `alu_src_b` and `imm_src`
  - FSM state encoding (4-bit)
- One sub-module, `alu_decoder`: combinational, maps `alu_op[1:0]`, `funct3` and `funct7_5` to `alu_ctrl` plus a `funct_illegal` flag. `alu_op` values: 00 add, 01 sub, 10 decode R, 11 decode I.

## Test plan
- Reset then `add x3,x1,x2` (opcode 0110011, f3 000, f7_5 0), `mem_ready=1` → states FETCH, DECODE, EXECUTER, ALUWB. `alu_ctrl=010` in EXECUTER; `reg_write=1` only in cycle 4.
- `sub` (f7_5 1) → `alu_ctrl=110`. `slti` (0010011, f3 010) → `alu_ctrl=111` with `alu_src_b=01`.
- `ld` with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total. `adr_src=1` during all 3 MEMREAD cycles; `reg_write` pulses once with `result_src=01`.
- `beq`, `zero=1` → `pc_write=1` in cycle 3. Same instruction with `zero=0` → `pc_write=0`. Both return to FETCH.
- `sd`, `mem_ready=0` for 3 cycles → `mem_write` high for 4 consecutive cycles, then FETCH. `rst` asserted on the 2nd of those cycles → `mem_write=0` that cycle, FETCH next.
- Opcode 1111111: with `MULTICYCLE_CTRL_TRAP_EN` → `illegal=1` and held until `rst`. Without it → back to FETCH in cycle 3 with no strobes.
